pll_phase_ctrl: RTL and testbench
=================================

PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

Interface
REQ-001 The block SHALL be parametrised as follows:
- NUM_OUTPUTS, default 4: number of phase-steppable PLL outputs (1..4).
- STEP_PULSE_CYCLES, default 4: width of each PHASESTEP low and high phase, in clkin cycles (>=1).
- SETTLE_CYCLES, default 8: wait after the last step before reporting done (>=1).
- LOCK_FILTER_CYCLES, default 16: consecutive synchronised-lock cycles needed before locked asserts (>=1).
- RST_CYCLES, default 16: PLL reset pulse width for relock.
- RELOCK_TIMEOUT, default 4096: lock wait before a relock retry.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with these ports:
- clkin  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  phase-step request.
- req_ready  out  1  request may be accepted.
- req_sel  in  2  PLL output index.
- req_dir  in  1  step direction, driven to pll_phasedir.
- req_steps  in  8  number of steps.
- done  out  1  one-cycle completion pulse.
- err_sel  out  1  one-cycle pulse: request rejected because req_sel >= NUM_OUTPUTS.
- err_abort  out  1  one-cycle pulse: operation aborted by loss of lock.
- busy  out  1  FSM not in IDLE.
- pll_lock  in  1  raw PLL LOCK, asynchronous.
- locked  out  1  filtered lock.
- pll_phasesel  out  2  PLL PHASESEL.
- pll_phasedir  out  1  PLL PHASEDIR.
- pll_phasestep  out  1  PLL PHASESTEP, idle high.
- pll_phaseloadreg  out  1  PLL PHASELOADREG, held 1.
- pll_rst  out  1  PLL RST.
- relock_count  out  8  saturating count of relock pulses issued.

Function
REQ-003 pll_lock SHALL pass through a 2-flop synchroniser; locked SHALL rise in cycle N+2+LOCK_FILTER_CYCLES, where N is the first cycle pll_lock is high, and SHALL fall 2 cycles after pll_lock falls; any low sample SHALL restart the filter.
REQ-004 FSM states SHALL be IDLE, SETUP, STEP_LO, STEP_HI, SETTLE and RELOCK (RELOCK exists only with the macro).
REQ-005 req_ready SHALL equal (state==IDLE && locked); acceptance SHALL occur on req_valid && req_ready.
REQ-006 An accepted request with req_sel >= NUM_OUTPUTS SHALL pulse err_sel in the next cycle, issue no step and stay in IDLE.
REQ-007 An accepted request with req_steps==0 SHALL pulse done in the next cycle and issue no step.
REQ-008 Any other accepted request SHALL latch sel, dir and steps, then proceed SETUP (2 cycles) -> STEP_LO -> STEP_HI -> SETTLE -> IDLE.
REQ-009 SETUP SHALL drive pll_phasesel and pll_phasedir, and hold them stable until SETTLE ends.
REQ-010 STEP_LO SHALL drive pll_phasestep=0 for STEP_PULSE_CYCLES cycles; STEP_HI SHALL drive pll_phasestep=1 for STEP_PULSE_CYCLES cycles.
REQ-011 After STEP_HI the step counter SHALL decrement; a nonzero remainder SHALL return to STEP_LO, zero SHALL go to SETTLE.
REQ-012 SETTLE SHALL last SETTLE_CYCLES cycles; done SHALL pulse on the first IDLE cycle, i.e. 2+steps*2*STEP_PULSE_CYCLES+SETTLE_CYCLES cycles after the acceptance cycle.
REQ-013 If locked falls in any non-IDLE state other than RELOCK, the FSM SHALL force pll_phasestep=1 in the same cycle it detects the fall, pulse err_abort, and not pulse done.
REQ-014 Counters SHALL be sized for their parameters without wrap; relock_count SHALL saturate at 255.

Reset
REQ-015 While rst is high, the outputs SHALL be: state IDLE; req_ready, done, err_sel, err_abort, busy, locked, pll_rst = 0; pll_phasestep and pll_phaseloadreg = 1; pll_phasesel and pll_phasedir = 0; relock_count = 0; synchroniser and filter cleared.
REQ-016 rst asserted mid-operation SHALL abandon the operation without a done or err pulse.

Configuration
REQ-017 With PLL_AUTO_RELOCK_EN defined, a fall of locked in any state SHALL enter RELOCK: pll_rst high for RST_CYCLES cycles (relock_count +1), then wait up to RELOCK_TIMEOUT cycles for locked; success -> IDLE, timeout -> repeat the pulse.
REQ-018 Without PLL_AUTO_RELOCK_EN, pll_rst and relock_count SHALL be constant 0, a lock loss SHALL go to IDLE, and the block SHALL wait there with req_ready=0 until locked returns.

Verification (STEP_PULSE_CYCLES=4, SETTLE_CYCLES=8, LOCK_FILTER_CYCLES=16, RST_CYCLES=16, NUM_OUTPUTS=3)
REQ-019 Release rst, pll_lock high from cycle 10 -> locked=1 and req_ready=1 from cycle 28.
REQ-020 Accept sel=1, dir=1, steps=3 -> pll_phasesel=1 and pll_phasedir=1; three 4-cycle low pulses 4 cycles apart; done 34 cycles after acceptance; busy high throughout.
REQ-021 Accept sel=3 -> err_sel pulse, pll_phasestep stays 1; steps=0 with sel=0 -> done the next cycle.
REQ-022 pll_lock low during the second STEP_LO -> pll_phasestep=1 and err_abort 2 cycles later; with the macro, pll_rst high 16 cycles and relock_count=1; without it, pll_rst stays 0.
REQ-023 With the macro, pll_lock held low -> pll_rst pulses every 16+RELOCK_TIMEOUT cycles; relock_count saturates at 255.
REQ-024 rst pulsed mid-STEP_LO -> all outputs at their REQ-015 values asynchronously, with no done or err pulse.

Source files
------------

// File: rtl/pll_phase_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// pll_phase_ctrl: lock filter plus FSM that sequences PLL PHASESTEP pulses for a selected output.
// Optional feature macro: PLL_AUTO_RELOCK_EN (automatic PLL reset and relock on loss of lock).
// Revision: 1.0
module pll_phase_ctrl #(
  parameter int NUM_OUTPUTS        = 4,
  parameter int STEP_PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES      = 8,
  parameter int LOCK_FILTER_CYCLES = 16,
  parameter int RST_CYCLES         = 16,
  parameter int RELOCK_TIMEOUT     = 4096
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [7:0] req_steps,
  output logic       done,
  output logic       err_sel,
  output logic       err_abort,
  output logic       busy,
  input  logic       pll_lock,
  output logic       locked,
  output logic [1:0] pll_phasesel,
  output logic       pll_phasedir,
  output logic       pll_phasestep,
  output logic       pll_phaseloadreg,
  output logic       pll_rst,
  output logic [7:0] relock_count
);

  localparam int TM0  = (STEP_PULSE_CYCLES > SETTLE_CYCLES) ? STEP_PULSE_CYCLES : SETTLE_CYCLES;
  localparam int TM1  = (TM0 > RST_CYCLES) ? TM0 : RST_CYCLES;
  localparam int TM2  = (TM1 > RELOCK_TIMEOUT) ? TM1 : RELOCK_TIMEOUT;
  localparam int TMAX = (TM2 > 2) ? TM2 : 2;
  localparam int TW   = $clog2(TMAX);
  localparam int FW   = (LOCK_FILTER_CYCLES > 1) ? $clog2(LOCK_FILTER_CYCLES) : 1;

  localparam logic [TW-1:0] SETUP_LAST  = TW'(1);
  localparam logic [TW-1:0] STEP_LAST   = TW'(STEP_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST   = FW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [2:0]    NUM_SEL     = 3'(NUM_OUTPUTS);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] STEP_LO = 3'd2;
  localparam logic [2:0] STEP_HI = 3'd3;
  localparam logic [2:0] SETTLE  = 3'd4;
`ifdef PLL_AUTO_RELOCK_EN
  localparam logic [2:0] RELOCK  = 3'd5;
  localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(RELOCK_TIMEOUT - 1);
`endif

  logic          sync_meta, sync_lock, filt_ok;
  logic [FW-1:0] filt_cnt;
  logic [2:0]    state, state_next;
  logic [TW-1:0] timer;
  logic          timer_clr;
  logic [7:0]    steps_left;
  logic          accept, sel_ok, steps_nz, abort;

  assign locked           = filt_ok & sync_lock;
  assign accept           = req_valid & req_ready;
  assign sel_ok           = {1'b0, req_sel} < NUM_SEL;
  assign steps_nz         = req_steps != 8'd0;
  assign abort            = !locked && (state inside {SETUP, STEP_LO, STEP_HI, SETTLE});
  assign pll_phaseloadreg = 1'b1;

  // Locked drops as soon as the synchronised sample drops; rising needs the full filter run.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_lock <= 1'b0;
      filt_cnt  <= '0;
      filt_ok   <= 1'b0;
    end else begin
      sync_meta <= pll_lock;
      sync_lock <= sync_meta;
      if (!sync_lock) begin
        filt_cnt <= '0;
        filt_ok  <= 1'b0;
      end else if (!filt_ok) begin
        if (filt_cnt == FILT_LAST) filt_ok <= 1'b1;
        else                       filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

`ifdef PLL_AUTO_RELOCK_EN
  logic locked_d, relock_wait, relock_wait_next;
  logic [7:0] relock_cnt;
  assign relock_count = relock_cnt;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      locked_d    <= 1'b0;
      relock_wait <= 1'b0;
      relock_cnt  <= 8'd0;
    end else begin
      locked_d    <= locked;
      relock_wait <= relock_wait_next;
      if (state == RELOCK && !relock_wait && timer == '0 && relock_cnt != 8'hFF)
        relock_cnt <= relock_cnt + 8'd1;
    end
  end
`else
  assign relock_count = 8'd0;
`endif

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      steps_left   <= 8'd0;
      pll_phasesel <= 2'd0;
      pll_phasedir <= 1'b0;
      done         <= 1'b0;
      err_sel      <= 1'b0;
    end else begin
      state   <= state_next;
      timer   <= (timer_clr || state == IDLE) ? '0 : timer + TW'(1);
      done    <= (accept && sel_ok && !steps_nz) ||
                 (state == SETTLE && timer == SETTLE_LAST && locked);
      err_sel <= accept && !sel_ok;
      if (accept && sel_ok && steps_nz) begin
        pll_phasesel <= req_sel;
        pll_phasedir <= req_dir;
        steps_left   <= req_steps;
      end else if (state == STEP_HI && timer == STEP_LAST) begin
        steps_left <= steps_left - 8'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    timer_clr  = 1'b0;
`ifdef PLL_AUTO_RELOCK_EN
    relock_wait_next = relock_wait;
`endif
    case (state)
      IDLE: begin
`ifdef PLL_AUTO_RELOCK_EN
        if (locked_d && !locked) state_next = RELOCK;
        else
`endif
        if (accept && sel_ok && steps_nz) state_next = SETUP;
      end
      SETUP:   if (timer == SETUP_LAST) state_next = STEP_LO;
      STEP_LO: if (timer == STEP_LAST)  state_next = STEP_HI;
      STEP_HI: if (timer == STEP_LAST)  state_next = (steps_left == 8'd1) ? SETTLE : STEP_LO;
      SETTLE:  if (timer == SETTLE_LAST) state_next = IDLE;
`ifdef PLL_AUTO_RELOCK_EN
      RELOCK: begin
        if (!relock_wait) begin
          if (timer == RST_LAST) begin
            relock_wait_next = 1'b1;
            timer_clr        = 1'b1;
          end
        end else if (locked) begin
          state_next = IDLE;
        end else if (timer == TIMEOUT_LAST) begin
          relock_wait_next = 1'b0;
          timer_clr        = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
    if (abort) begin
`ifdef PLL_AUTO_RELOCK_EN
      state_next = RELOCK;
`else
      state_next = IDLE;
`endif
    end
`ifdef PLL_AUTO_RELOCK_EN
    if (state_next == RELOCK && state != RELOCK) relock_wait_next = 1'b0;
`endif
    if (state_next != state) timer_clr = 1'b1;
  end

  // PHASESTEP is released in the very cycle lock loss is seen, before the state moves.
  always_comb begin
    busy          = state != IDLE;
    req_ready     = (state == IDLE) && locked;
    pll_phasestep = !(state == STEP_LO && locked);
    err_abort     = abort;
`ifdef PLL_AUTO_RELOCK_EN
    pll_rst       = (state == RELOCK) && !relock_wait;
`else
    pll_rst       = 1'b0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_phase_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// tb_pll_phase_ctrl: directed table-driven bench for pll_phase_ctrl (NUM_OUTPUTS=3).
module tb_pll_phase_ctrl;

  localparam int NUM = 3, P = 4, S = 8, F = 16, R = 16, TO = 64;

  logic       clkin = 1'b0, rst = 1'b1;
  logic       req_valid = 1'b0, req_dir = 1'b0, pll_lock = 1'b0;
  logic [1:0] req_sel = 2'd0;
  logic [7:0] req_steps = 8'd0;
  logic       req_ready, done, err_sel, err_abort, busy, locked;
  logic [1:0] pll_phasesel;
  logic       pll_phasedir, pll_phasestep, pll_phaseloadreg, pll_rst;
  logic [7:0] relock_count;

  pll_phase_ctrl #(
    .NUM_OUTPUTS(NUM), .STEP_PULSE_CYCLES(P), .SETTLE_CYCLES(S),
    .LOCK_FILTER_CYCLES(F), .RST_CYCLES(R), .RELOCK_TIMEOUT(TO)
  ) dut (
    .clkin(clkin), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps), .done(done),
    .err_sel(err_sel), .err_abort(err_abort), .busy(busy), .pll_lock(pll_lock),
    .locked(locked), .pll_phasesel(pll_phasesel), .pll_phasedir(pll_phasedir),
    .pll_phasestep(pll_phasestep), .pll_phaseloadreg(pll_phaseloadreg),
    .pll_rst(pll_rst), .relock_count(relock_count)
  );

  always #5 clkin = ~clkin;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clkin);
      #1;
    end
  endtask

  // Returns one cycle after the accepting edge (k=0).
  task automatic do_accept(input logic [1:0] s, input logic d, input logic [7:0] n);
    int w;
    w = 0;
    while (!req_ready && w < 300) begin
      tick();
      w++;
    end
    chk("ready_wait", int'(req_ready), 1);
    req_sel = s; req_dir = d; req_steps = n; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0] sel;
    logic       dir;
    logic [7:0] steps;
    int exp_done, exp_err, exp_k, exp_lows, exp_pulses, exp_busy, exp_psel, exp_pdir;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k_ev, lows, pulses, busy_n, dseen, eseen, cnt, dn, w;
    logic prev;

    // sel, dir, steps | done, err, event cycle, low cycles, low pulses, busy cycles, phasesel, phasedir
    vecs[0] = '{2'd1, 1'b1, 8'd3, 1, 0, 34, 12, 3, 34, 1, 1};
    vecs[1] = '{2'd3, 1'b0, 8'd5, 0, 1,  0,  0, 0,  0, 1, 1};
    vecs[2] = '{2'd0, 1'b0, 8'd0, 1, 0,  0,  0, 0,  0, 1, 1};
    vecs[3] = '{2'd2, 1'b0, 8'd1, 1, 0, 18,  4, 1, 18, 2, 0};
    vecs[4] = '{2'd0, 1'b1, 8'd2, 1, 0, 26,  8, 2, 26, 0, 1};

    tick(3);
    chk("rst_locked", int'(locked), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err_sel", int'(err_sel), 0);
    chk("rst_err_abort", int'(err_abort), 0);
    chk("rst_pll_rst", int'(pll_rst), 0);
    chk("rst_phasestep", int'(pll_phasestep), 1);
    chk("rst_loadreg", int'(pll_phaseloadreg), 1);
    chk("rst_phasesel", int'(pll_phasesel), 0);
    chk("rst_phasedir", int'(pll_phasedir), 0);
    chk("rst_relock_count", int'(relock_count), 0);

    rst = 1'b0;
    tick(10);
    pll_lock = 1'b1;
    tick(17);
    chk("lock_cycle27", int'(locked), 0);
    tick();
    chk("lock_cycle28", int'(locked), 1);
    chk("ready_cycle28", int'(req_ready), 1);

    for (int i = 0; i < 5; i++) begin
      k_ev = -1; lows = 0; pulses = 0; busy_n = 0; dseen = 0; eseen = 0; prev = 1'b1;
      do_accept(vecs[i].sel, vecs[i].dir, vecs[i].steps);
      for (int k = 0; k < 100; k++) begin
        if (!pll_phasestep) begin
          lows++;
          if (prev) pulses++;
        end
        prev = pll_phasestep;
        if (busy) busy_n++;
        if (done || err_sel) begin
          k_ev = k; dseen = int'(done); eseen = int'(err_sel);
          break;
        end
        tick();
      end
      chk($sformatf("v%0d_event_cycle", i), k_ev, vecs[i].exp_k);
      chk($sformatf("v%0d_done", i), dseen, vecs[i].exp_done);
      chk($sformatf("v%0d_err_sel", i), eseen, vecs[i].exp_err);
      chk($sformatf("v%0d_low_cycles", i), lows, vecs[i].exp_lows);
      chk($sformatf("v%0d_low_pulses", i), pulses, vecs[i].exp_pulses);
      chk($sformatf("v%0d_busy_cycles", i), busy_n, vecs[i].exp_busy);
      chk($sformatf("v%0d_phasesel", i), int'(pll_phasesel), vecs[i].exp_psel);
      chk($sformatf("v%0d_phasedir", i), int'(pll_phasedir), vecs[i].exp_pdir);
    end

    // Lock loss during the second STEP_LO (cycles 10..13 after acceptance).
    do_accept(2'd0, 1'b0, 8'd3);
    tick(10);
    chk("abort_k10_step", int'(pll_phasestep), 0);
    pll_lock = 1'b0;
    tick();
    chk("abort_k11_step", int'(pll_phasestep), 0);
    chk("abort_k11_err", int'(err_abort), 0);
    tick();
    chk("abort_k12_step", int'(pll_phasestep), 1);
    chk("abort_k12_err", int'(err_abort), 1);
    chk("abort_k12_done", int'(done), 0);
    tick();
    chk("abort_k13_err", int'(err_abort), 0);
`ifdef PLL_AUTO_RELOCK_EN
    chk("abort_k13_busy", int'(busy), 1);
    cnt = 0; dn = 0;
    for (int j = 0; j < R + TO; j++) begin
      if (pll_rst) cnt++;
      if (done) dn++;
      tick();
    end
    chk("relock_rst_cycles", cnt, R);
    chk("relock_count_1", int'(relock_count), 1);
    chk("abort_no_done", dn, 0);
    pll_lock = 1'b1;
    w = 0;
    while (!req_ready && w < 300) begin tick(); w++; end
    chk("relock_ready", int'(req_ready), 1);
    chk("relock_count_2", int'(relock_count), 2);

    pll_lock = 1'b0;
    w = 0;
    while (relock_count != 8'hFF && w < 25000) begin tick(); w++; end
    tick(200);
    chk("relock_saturate", int'(relock_count), 255);
    pll_lock = 1'b1;
    w = 0;
    while (!req_ready && w < 300) begin tick(); w++; end
    chk("relock_final_ready", int'(req_ready), 1);
`else
    chk("abort_k13_busy", int'(busy), 0);
    chk("abort_k13_ready", int'(req_ready), 0);
    pll_lock = 1'b1;
    dn = 0; cnt = 0;
    for (int j = 0; j < 2 + F; j++) begin
      tick();
      if (done) dn++;
      if (pll_rst) cnt++;
      if (j == 16) chk("relock_ready_early", int'(req_ready), 0);
    end
    chk("relock_ready", int'(req_ready), 1);
    chk("abort_no_done", dn, 0);
    chk("no_pll_rst", cnt, 0);
`endif

    // Asynchronous reset in the middle of STEP_LO.
    do_accept(2'd2, 1'b1, 8'd2);
    tick(3);
    chk("rst_mid_pre_step", int'(pll_phasestep), 0);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_step", int'(pll_phasestep), 1);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ready", int'(req_ready), 0);
    chk("rst_mid_locked", int'(locked), 0);
    chk("rst_mid_phasesel", int'(pll_phasesel), 0);
    chk("rst_mid_phasedir", int'(pll_phasedir), 0);
    chk("rst_mid_relock_count", int'(relock_count), 0);
    dn = 0;
    for (int j = 0; j < 3; j++) begin
      if (done || err_sel || err_abort || pll_rst) dn++;
      tick();
    end
    chk("rst_mid_no_pulse", dn, 0);
    rst = 1'b0;
    tick(17);
    chk("rst_relock_early", int'(locked), 0);
    tick();
    chk("rst_relock", int'(locked), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
